// File: rtl/music_mode_ctrl_pkg.sv
// Mode encodings shared between the mode controller and the downstream music player.
package music_pkg;

  typedef enum logic [2:0] {
    MODE_IDLE     = 3'b000,
    MODE_ASC      = 3'b001,
    MODE_DESC     = 3'b010,
    MODE_ASC_DESC = 3'b011
  } mode_t;

  function automatic mode_t next_mode(input mode_t m);
    case (m)
      MODE_IDLE:     next_mode = MODE_ASC;
      MODE_ASC:      next_mode = MODE_DESC;
      MODE_DESC:     next_mode = MODE_ASC_DESC;
      default:       next_mode = MODE_IDLE;
    endcase
  endfunction

  // Automatic stepping never returns to IDLE; it cycles among the playing modes.
  function automatic mode_t auto_next_mode(input mode_t m);
    case (m)
      MODE_ASC:      auto_next_mode = MODE_DESC;
      MODE_DESC:     auto_next_mode = MODE_ASC_DESC;
      default:       auto_next_mode = MODE_ASC;
    endcase
  endfunction

endpackage

// File: rtl/music_mode_ctrl_btn_debounce.sv
// Button conditioner: 2-FF synchronizer, stable-level debouncer, registered press pulse.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic press_o
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic             sync1_q, sync2_q;
  logic             deb_q, deb_dly_q, press_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      deb_q     <= 1'b0;
      deb_dly_q <= 1'b0;
      press_q   <= 1'b0;
      cnt_q     <= '0;
    end else begin
      sync1_q   <= btn_i;
      sync2_q   <= sync1_q;
      deb_dly_q <= deb_q;
      press_q   <= deb_q & ~deb_dly_q;
      // Accept the new level on the Nth consecutive mismatching cycle.
      if (sync2_q != deb_q) begin
        if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          deb_q <= sync2_q;
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/music_mode_ctrl.sv
// Playback mode selector and beep request generator driven by two debounced buttons.
// Optional auto-advance timer enabled by defining MUSIC_AUTO_ADVANCE_EN.
module music_mode_ctrl
  import music_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int BEEP_CYCLES     = 50_000_000,
  parameter int AUTO_PERIOD     = 200_000_000
) (
  input  logic       clk_100mHz,
  input  logic       rst,
  input  logic       btn_next,
  input  logic       btn_beep,
  output logic [2:0] mode,
  output logic       beep_trigger,
  output logic       beep_busy_pulse
);

  localparam int BEEP_W = (BEEP_CYCLES > 1) ? $clog2(BEEP_CYCLES) : 1;

  if (DEBOUNCE_CYCLES < 1 || BEEP_CYCLES < 1 || AUTO_PERIOD < 1) begin : g_bad_param
    $error("music_mode_ctrl: cycle parameters must be at least 1");
  end

  logic              next_press, beep_press;
  mode_t             mode_q, mode_d;
  logic              trig_q, busy_q;
  logic [BEEP_W-1:0] beep_cnt_q;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next (
    .clk_i  (clk_100mHz),
    .rst_i  (rst),
    .btn_i  (btn_next),
    .press_o(next_press)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_beep (
    .clk_i  (clk_100mHz),
    .rst_i  (rst),
    .btn_i  (btn_beep),
    .press_o(beep_press)
  );

`ifdef MUSIC_AUTO_ADVANCE_EN
  localparam int AUTO_W = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;

  logic [AUTO_W-1:0] auto_cnt_q, auto_cnt_d;

  // A manual press wins over a timer expiry landing on the same cycle.
  always_comb begin
    mode_d     = mode_q;
    auto_cnt_d = auto_cnt_q;
    if (next_press) begin
      mode_d     = next_mode(mode_q);
      auto_cnt_d = '0;
    end else if (mode_q == MODE_IDLE) begin
      auto_cnt_d = '0;
    end else if (auto_cnt_q == AUTO_W'(AUTO_PERIOD - 1)) begin
      mode_d     = auto_next_mode(mode_q);
      auto_cnt_d = '0;
    end else begin
      auto_cnt_d = auto_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_100mHz) begin
    if (rst) auto_cnt_q <= '0;
    else     auto_cnt_q <= auto_cnt_d;
  end
`else
  always_comb begin
    mode_d = next_press ? next_mode(mode_q) : mode_q;
  end
`endif

  always_ff @(posedge clk_100mHz) begin
    if (rst) begin
      mode_q     <= MODE_IDLE;
      trig_q     <= 1'b0;
      busy_q     <= 1'b0;
      beep_cnt_q <= '0;
    end else begin
      mode_q <= mode_d;
      busy_q <= beep_press & trig_q;
      // beep_cnt_q holds the remaining high cycles after the current one.
      if (trig_q) begin
        if (beep_cnt_q == '0) trig_q     <= 1'b0;
        else                  beep_cnt_q <= beep_cnt_q - 1'b1;
      end else if (beep_press) begin
        trig_q     <= 1'b1;
        beep_cnt_q <= BEEP_W'(BEEP_CYCLES - 1);
      end
    end
  end

  assign mode            = mode_q;
  assign beep_trigger    = trig_q;
  assign beep_busy_pulse = busy_q;

endmodule

// File: doc/music_mode_ctrl.md
MUSIC_MODE_CTRL -- requirements
Module: music_mode_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 1_000_000, number of stable cycles to accept a button level (min 1).
REQ-002 SHALL have parameter BEEP_CYCLES, default 50_000_000, beep_trigger high time in cycles (min 1).
REQ-003 SHALL have parameter AUTO_PERIOD, default 200_000_000, auto-advance interval in cycles (used only under MUSIC_AUTO_ADVANCE_EN).
REQ-004 SHALL have port clk_100mHz, input, 1 bit, sole clock, all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-006 SHALL have port btn_next, input, 1 bit, raw asynchronous mode-advance button, high = pressed.
REQ-007 SHALL have port btn_beep, input, 1 bit, raw asynchronous beep button, high = pressed.
REQ-008 SHALL have port mode, output, 3 bits, selected playback mode to the downstream music player.
REQ-009 SHALL have port beep_trigger, output, 1 bit, high while a beep is requested.
REQ-010 SHALL have port beep_busy_pulse, output, 1 bit, one-cycle pulse when a beep press is ignored because a beep is active.

Function
REQ-011 Each button SHALL pass through a 2-FF synchronizer then a debouncer; debounced level changes only after the synchronized level differs from it for DEBOUNCE_CYCLES consecutive cycles; any mismatch-free cycle restarts the count.
REQ-012 A one-cycle press event SHALL fire on each debounced 0->1 transition; release fires nothing; press event is asserted DEBOUNCE_CYCLES+3 cycles after raw input first sampled high and held stable.
REQ-013 Mode FSM states and encodings: IDLE 3'b000, ASC 3'b001, DESC 3'b010, ASC_DESC 3'b011; no other value ever driven.
REQ-014 On a next press event mode SHALL advance IDLE->ASC->DESC->ASC_DESC->IDLE, updating mode on the cycle after the event.
REQ-015 On a beep press event with beep_trigger low, beep_trigger SHALL go high the next cycle and stay high exactly BEEP_CYCLES cycles, then low.
REQ-016 A beep press event while beep_trigger high SHALL NOT extend or restart the beep; beep_busy_pulse SHALL be high for the following cycle.
REQ-017 Beep press event on the cycle beep_trigger falls (last high cycle) SHALL be treated as busy (ignored, busy pulse).
REQ-018 Simultaneous next and beep events SHALL both take effect in the same cycle; mode changes during a beep SHALL not disturb the beep timer.
REQ-019 Glitches shorter than DEBOUNCE_CYCLES SHALL produce no event and no output change.

Reset
REQ-020 While rst high: mode = 3'b000, beep_trigger = 0, beep_busy_pulse = 0, synchronizers/debounced levels = 0, all counters = 0.
REQ-021 Reset mid-beep SHALL drop beep_trigger the cycle after rst is sampled high; a button held through reset release SHALL generate a press event after full debounce (debounced level starts at 0).

Configuration
REQ-022 Macro MUSIC_AUTO_ADVANCE_EN defined: when mode != IDLE, a timer advances mode every AUTO_PERIOD cycles through ASC->DESC->ASC_DESC->ASC (skips IDLE); any next press event reloads the timer; entering IDLE clears it.
REQ-023 Macro undefined: no timer logic present; mode changes only on next press events or reset.

Structure
REQ-024 Package music_pkg SHALL hold the mode encodings (MODE_IDLE, MODE_ASC, MODE_DESC, MODE_ASC_DESC) and the 3-bit mode type, shared with the music player.
REQ-025 Synchronizer+debouncer+edge detect SHALL be one sub-module btn_debounce, instantiated twice.
REQ-026 Counter widths SHALL be derived from parameters via $clog2; no counter may wrap at its terminal value.

Verification (DEBOUNCE_CYCLES=4, BEEP_CYCLES=10, AUTO_PERIOD=20)
REQ-027 Reset, then btn_next held high -> press event at cycle 7, mode=001 at cycle 8; three more clean presses -> 010, 011, 000.
REQ-028 btn_next high for 3 cycles then low -> no event, mode stays 000.
REQ-029 Clean btn_beep press -> beep_trigger high exactly 10 cycles; second press during beep -> beep_busy_pulse one cycle, beep still ends at cycle 10.
REQ-030 btn_next and btn_beep pressed same cycle -> mode advances and beep_trigger rises in the same cycle.
REQ-031 rst asserted at beep cycle 5 -> beep_trigger low next cycle, mode=000.
REQ-032 With MUSIC_AUTO_ADVANCE_EN, mode=001 -> 010 after 20 cycles, 011 after 40, 001 after 60; without macro mode stays 001.
